clock_div_prog: RTL

- Multi-channel programmable clock divider. It generates NUM_CH independent divided clock-enable waveforms from the single system clock. Each channel has its own period and high-time, which can be changed at run time.
- Every channel also drives a one-cycle tick pulse at each period boundary.
- It feeds display scanning, key debounce and blink timing in the calculator datapath. New divisors take effect glitch-free at the next period boundary.

---
 rtl/clock_div_prog.sv | 132 +++++++++++++
 1 files changed

// File: rtl/clock_div_prog.sv
// Multi-channel programmable clock divider: each channel runs its own period
// and high-time, with shadow registers that swap in at the period boundary.
module clock_div_prog #(
  parameter int NUM_CH     = 2,
  parameter int CNT_W      = 28,
  parameter int CH_W       = 1,
  parameter int DEF_PERIOD = 100000,
  parameter int DEF_HIGH   = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              load,
  input  logic [CH_W-1:0]   load_ch,
  input  logic [CNT_W-1:0]  load_period,
  input  logic [CNT_W-1:0]  load_high,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pending,
  output logic              load_err
);

  localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEF_PERIOD);
  localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEF_HIGH);

  logic [31:0] load_idx;
  logic        load_bad;
  logic        load_ok;
  logic        load_err_d;
  logic        load_err_q;

  // A rejected load only raises load_err; it never touches channel state.
  always_comb begin
    load_idx   = 32'(load_ch);
    load_bad   = (load_idx >= 32'(NUM_CH)) ||
                 (load_period < CNT_W'(2)) ||
                 (load_high == '0) ||
                 (load_high >= load_period);
    load_ok    = load && !load_bad;
    load_err_d = load && load_bad;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_err_q <= 1'b0;
    end else begin
      load_err_q <= load_err_d;
    end
  end

  assign load_err = load_err_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] sh_per_q, sh_per_d;
    logic [CNT_W-1:0] sh_high_q, sh_high_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             hit;
    logic             wrap;

    // The apply path reads the pre-edge shadow, so a load landing on the same
    // edge only refills the shadow and waits for the following boundary.
    always_comb begin
      hit       = load_ok && (load_idx == 32'(i));
      wrap      = (cnt_q == (per_q - CNT_W'(1)));
      cnt_d     = cnt_q;
      per_d     = per_q;
      high_d    = high_q;
      sh_per_d  = sh_per_q;
      sh_high_d = sh_high_q;
      pend_d    = pend_q;
      clk_d     = clk_q;
      tick_d    = 1'b0;
      if (en[i]) begin
        tick_d = wrap;
        if (wrap) begin
          cnt_d = '0;
          if (pend_q) begin
            per_d  = sh_per_q;
            high_d = sh_high_q;
            pend_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        clk_d = (cnt_d < high_d);
      end else if (pend_q) begin
        per_d  = sh_per_q;
        high_d = sh_high_q;
        pend_d = 1'b0;
        cnt_d  = '0;
        clk_d  = 1'b0;
      end
      if (hit) begin
        sh_per_d  = load_period;
        sh_high_d = load_high;
        pend_d    = 1'b1;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q     <= '0;
        per_q     <= DEF_P;
        high_q    <= DEF_H;
        sh_per_q  <= DEF_P;
        sh_high_q <= DEF_H;
        pend_q    <= 1'b0;
        clk_q     <= 1'b0;
        tick_q    <= 1'b0;
      end else begin
        cnt_q     <= cnt_d;
        per_q     <= per_d;
        high_q    <= high_d;
        sh_per_q  <= sh_per_d;
        sh_high_q <= sh_high_d;
        pend_q    <= pend_d;
        clk_q     <= clk_d;
        tick_q    <= tick_d;
      end
    end

    assign clk_out[i] = clk_q;
    assign tick[i]    = tick_q;
    assign pending[i] = pend_q;
  end

endmodule
